// File: rtl/rv_mem_arbiter.sv
// Arbiter sharing one single-port synchronous-read memory between instruction
// fetch, data load/store and a word-write loader. It grants one requester per
// cycle, returns read data one cycle after the grant, and bounds fetch waiting
// with a saturating starvation counter.
module rv_mem_arbiter #(
   parameter int MEM_SIZE_WORDS = 256,
   parameter int MEM_AW         = $clog2(MEM_SIZE_WORDS),
   parameter int STARVE_LIMIT   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [3:0]        d_byte_en,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   input  logic              ld_req,
   input  logic [31:0]       ld_addr,
   input  logic [31:0]       ld_wdata,
   output logic              ld_gnt,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_byte_en,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_FETCH,
      OWN_DATA
   } owner_t;

   owner_t     rd_owner_q;
   owner_t     rd_owner_d;
   logic [3:0] starve_cnt;
   logic [3:0] starve_cnt_d;
   logic       promote;

   // Byte-offset bits and bits above the memory depth are dropped (address wraps).
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr, d_addr, ld_addr};

   // Grant selection: loader always wins; fetch jumps ahead of data once starved.
   always_comb begin
      ld_gnt  = 1'b0;
      d_gnt   = 1'b0;
      if_gnt  = 1'b0;
      promote = (starve_cnt == LIMIT);
      if (rst_n) begin
         if (ld_req) begin
            ld_gnt = 1'b1;
         end else if (promote && if_req) begin
            if_gnt = 1'b1;
         end else if (d_req) begin
            d_gnt = 1'b1;
         end else if (if_req) begin
            if_gnt = 1'b1;
         end
      end
   end

   // Memory port drive for whichever requester holds the grant; idle is all zero.
   always_comb begin
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_byte_en = '0;
      mem_addr    = '0;
      mem_wdata   = '0;
      if (ld_gnt) begin
         mem_en      = 1'b1;
         mem_we      = 1'b1;
         mem_byte_en = '1;
         mem_addr    = ld_addr[MEM_AW+1:2];
         mem_wdata   = ld_wdata;
      end else if (d_gnt) begin
         mem_en      = 1'b1;
         mem_we      = d_we;
         mem_byte_en = d_byte_en;
         mem_addr    = d_addr[MEM_AW+1:2];
         mem_wdata   = d_wdata;
      end else if (if_gnt) begin
         mem_en      = 1'b1;
         mem_we      = 1'b0;
         mem_byte_en = '1;
         mem_addr    = if_addr[MEM_AW+1:2];
      end
   end

   // Next read owner and next starvation count.
   always_comb begin
      rd_owner_d   = OWN_NONE;
      starve_cnt_d = '0;
      if (if_gnt) begin
         rd_owner_d = OWN_FETCH;
      end else if (d_gnt && !d_we) begin
         rd_owner_d = OWN_DATA;
      end
      if (if_req && !if_gnt) begin
         starve_cnt_d = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
      end
   end

   // State registers; reset discards any read still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_owner_q <= OWN_NONE;
         starve_cnt <= '0;
      end else begin
         rd_owner_q <= rd_owner_d;
         starve_cnt <= starve_cnt_d;
      end
   end

   // Read return routed to the owner of last cycle's read; the other side sees zero.
   always_comb begin
      if_rvalid = (rd_owner_q == OWN_FETCH);
      d_rvalid  = (rd_owner_q == OWN_DATA);
      if_rdata  = '0;
      d_rdata   = '0;
      if (if_rvalid) begin
         if_rdata = mem_rdata;
      end
      if (d_rvalid) begin
         d_rdata = mem_rdata;
      end
   end

endmodule
